// File: rtl/host_tx.sv
// host_tx: 8N1 serial transmitter for keyboard bytes plus the VT52 identify
// response (ESC '/' 'K'). Keyboard bytes arrive over a valid/ready handshake;
// identify requests queue a three-byte sequence that is never interleaved
// with keyboard traffic and only takes priority at byte boundaries.
module host_tx #(
  parameter int unsigned BAUD_DIV = 2500
) (
  input  logic       clk,
  input  logic       clr_n,
  input  logic [7:0] data,
  input  logic       valid,
  output logic       ready,
  input  logic       ident_req,
  output logic       tx,
  output logic       busy
);

  typedef enum logic [1:0] {
    StIdle,
    StStart,
    StData,
    StStop
  } state_e;

  // Value loaded into the baud counter on entry to every non-idle state.
  localparam logic [15:0] BaudLoad = 16'(BAUD_DIV - 1);

  state_e      state_q, state_d;
  logic [15:0] cnt_q, cnt_d;
  logic [2:0]  bit_q, bit_d;
  logic [7:0]  shift_q, shift_d;
  logic        ident_pend_q, ident_pend_d;
  logic [1:0]  seq_idx_q, seq_idx_d;
  logic        tx_q, tx_d;
  logic        busy_q, busy_d;

  logic        seq_active;
  logic        cnt_done;
  logic [7:0]  seq_byte;

  // An identify sequence is owed or partly sent; blocks keyboard acceptance.
  assign seq_active = ident_pend_q || (seq_idx_q != 2'd0);
  assign cnt_done   = (cnt_q == 16'd0);
  assign ready      = (state_q == StIdle) && !seq_active;
  assign tx         = tx_q;
  assign busy       = busy_q;

  // Identify response byte for the current sequence position.
  always_comb begin
    case (seq_idx_q)
      2'd0:    seq_byte = 8'h1B;
      2'd1:    seq_byte = 8'h2F;
      2'd2:    seq_byte = 8'h4B;
      default: seq_byte = 8'h1B;
    endcase
  end

  // Frame sequencing, byte selection and identify bookkeeping.
  always_comb begin
    state_d      = state_q;
    cnt_d        = cnt_q;
    bit_d        = bit_q;
    shift_d      = shift_q;
    ident_pend_d = ident_pend_q;
    seq_idx_d    = seq_idx_q;

    unique case (state_q)
      StIdle: begin
        if (seq_active) begin
          // Identify bytes win at a byte boundary over a waiting keyboard byte.
          shift_d = seq_byte;
          state_d = StStart;
          cnt_d   = BaudLoad;
          bit_d   = 3'd0;
          if (seq_idx_q == 2'd0) begin
            ident_pend_d = 1'b0;
            seq_idx_d    = 2'd1;
          end else if (seq_idx_q == 2'd1) begin
            seq_idx_d = 2'd2;
          end else begin
            seq_idx_d = 2'd0;
          end
        end else if (valid) begin
          shift_d = data;
          state_d = StStart;
          cnt_d   = BaudLoad;
          bit_d   = 3'd0;
        end
      end

      StStart: begin
        if (cnt_done) begin
          state_d = StData;
          cnt_d   = BaudLoad;
          bit_d   = 3'd0;
        end else begin
          cnt_d = cnt_q - 16'd1;
        end
      end

      StData: begin
        if (cnt_done) begin
          cnt_d   = BaudLoad;
          shift_d = {1'b0, shift_q[7:1]};
          if (bit_q == 3'd7) begin
            state_d = StStop;
          end else begin
            bit_d = bit_q + 3'd1;
          end
        end else begin
          cnt_d = cnt_q - 16'd1;
        end
      end

      StStop: begin
        if (cnt_done) begin
          state_d = StIdle;
        end else begin
          cnt_d = cnt_q - 16'd1;
        end
      end

      default: begin
        state_d = StIdle;
        cnt_d   = 16'd0;
      end
    endcase

    // A request in any state is remembered; repeats before byte 0 merge.
    if (ident_req) begin
      ident_pend_d = 1'b1;
    end
  end

  // Line level and busy are computed from next state so they are registered
  // yet change on the same edge as the state they describe.
  always_comb begin
    tx_d = 1'b1;
    unique case (state_d)
      StStart: tx_d = 1'b0;
      StData:  tx_d = shift_d[0];
      default: tx_d = 1'b1;
    endcase
    busy_d = (state_d != StIdle) || ident_pend_d || (seq_idx_d != 2'd0);
  end

  // State register; reset drops any frame and any owed identify bytes.
  always_ff @(posedge clk or negedge clr_n) begin
    if (!clr_n) begin
      state_q      <= StIdle;
      cnt_q        <= 16'd0;
      bit_q        <= 3'd0;
      shift_q      <= 8'd0;
      ident_pend_q <= 1'b0;
      seq_idx_q    <= 2'd0;
      tx_q         <= 1'b1;
      busy_q       <= 1'b0;
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      bit_q        <= bit_d;
      shift_q      <= shift_d;
      ident_pend_q <= ident_pend_d;
      seq_idx_q    <= seq_idx_d;
      tx_q         <= tx_d;
      busy_q       <= busy_d;
    end
  end

endmodule

// File: tb/tb_host_tx.sv
// Directed bench for host_tx with BAUD_DIV=4: a table of keyboard bytes with
// hand-computed 8N1 frames, then identify, overlap and reset sequences.
module tb_host_tx;

  localparam int unsigned BaudDiv  = 4;
  localparam int unsigned FrameCyc = 10 * BaudDiv;

  logic       clk = 1'b0;
  logic       clr_n = 1'b1;
  logic [7:0] data = 8'h00;
  logic       valid = 1'b0;
  logic       ident_req = 1'b0;
  logic       ready;
  logic       tx;
  logic       busy;

  int unsigned checks = 0;
  int unsigned errors = 0;
  int unsigned cyc = 0;

  // Frames as line order bit 0 first: {stop=1, data, start=0}.
  typedef struct {
    logic [7:0] data;
    logic [9:0] frame;
  } vec_t;

  vec_t       vecs[5];
  logic [9:0] id_frame[3];

  host_tx #(.BAUD_DIV(BaudDiv)) dut (
    .clk      (clk),
    .clr_n    (clr_n),
    .data     (data),
    .valid    (valid),
    .ready    (ready),
    .ident_req(ident_req),
    .tx       (tx),
    .busy     (busy)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, got, exp);
    end
  endtask

  // Called at a negedge; waits (bounded) for ready, then offers one byte.
  task automatic send(input string name, input logic [7:0] b, input logic with_ident);
    bit ok;
    ok = 1'b0;
    for (int i = 0; i < 300; i++) begin
      if (ready === 1'b1) begin
        ok = 1'b1;
        break;
      end
      @(negedge clk);
    end
    check({name, " ready wait"}, 32'(ok), 32'd1);
    valid     = 1'b1;
    data      = b;
    ident_req = with_ident;
    @(negedge clk);
    valid     = 1'b0;
    ident_req = 1'b0;
    data      = ~b;
  endtask

  // Waits for a start bit, samples the whole frame every cycle, and returns at
  // the negedge of the cycle after the stop bit.
  task automatic check_frame(input string name, input logic [9:0] exp,
                             output int unsigned start_cyc, output int unsigned ready_low,
                             output int unsigned busy_low);
    bit         seen;
    bit         stable;
    logic [9:0] got;
    seen      = 1'b0;
    stable    = 1'b1;
    got       = '0;
    start_cyc = 0;
    ready_low = 0;
    busy_low  = 0;
    for (int i = 0; i < 300; i++) begin
      if (tx === 1'b0) begin
        seen = 1'b1;
        break;
      end
      @(negedge clk);
    end
    check({name, " start seen"}, 32'(seen), 32'd1);
    if (!seen) return;
    start_cyc = cyc;
    for (int i = 0; i < int'(FrameCyc); i++) begin
      if ((i % int'(BaudDiv)) == 0) got[i / int'(BaudDiv)] = tx;
      else if (tx !== got[i / int'(BaudDiv)]) stable = 1'b0;
      if (ready !== 1'b1) ready_low++;
      if (busy !== 1'b1) busy_low++;
      @(negedge clk);
    end
    check({name, " frame"}, 32'({stable, got}), 32'({1'b1, exp}));
  endtask

  task automatic ident_seq(input string name, input int unsigned prev_start,
                           output int unsigned last_start);
    int unsigned s, rl, bl, prev;
    prev = prev_start;
    for (int k = 0; k < 3; k++) begin
      check_frame($sformatf("%s id%0d", name, k), id_frame[k], s, rl, bl);
      check($sformatf("%s id%0d ready low", name, k), 32'(rl), 32'(FrameCyc));
      check($sformatf("%s id%0d busy low", name, k), 32'(bl), 32'd0);
      if (prev != 0) check($sformatf("%s id%0d period", name, k), 32'(s - prev), 32'(FrameCyc + 1));
      check($sformatf("%s id%0d gap tx", name, k), 32'(tx), 32'd1);
      check($sformatf("%s id%0d gap ready", name, k), 32'(ready), 32'(k == 2));
      check($sformatf("%s id%0d gap busy", name, k), 32'(busy), 32'(k != 2));
      prev = s;
    end
    last_start = prev;
  endtask

  initial begin
    int unsigned s, rl, bl, prev, last;
    bit          dev;

    vecs[0] = '{8'h41, 10'h282};
    vecs[1] = '{8'h00, 10'h200};
    vecs[2] = '{8'hFF, 10'h3FE};
    vecs[3] = '{8'h55, 10'h2AA};
    vecs[4] = '{8'hA5, 10'h34A};
    id_frame[0] = 10'h236;  // 0x1B
    id_frame[1] = 10'h25E;  // 0x2F
    id_frame[2] = 10'h296;  // 0x4B

    // Reset values, then idle stability with no stimulus.
    #2 clr_n = 1'b0;
    repeat (2) @(negedge clk);
    check("reset tx", 32'(tx), 32'd1);
    check("reset ready", 32'(ready), 32'd1);
    check("reset busy", 32'(busy), 32'd0);
    clr_n = 1'b1;
    dev = 1'b0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (tx !== 1'b1 || ready !== 1'b1 || busy !== 1'b0) dev = 1'b1;
    end
    check("idle stable", 32'(dev), 32'd0);

    // Keyboard byte table, back to back.
    prev = 0;
    for (int i = 0; i < 5; i++) begin
      string n;
      n = $sformatf("kb%0d", i);
      send(n, vecs[i].data, 1'b0);
      check_frame(n, vecs[i].frame, s, rl, bl);
      check({n, " ready low"}, 32'(rl), 32'(FrameCyc));
      check({n, " busy low"}, 32'(bl), 32'd0);
      if (i > 0) check({n, " period"}, 32'(s - prev), 32'(FrameCyc + 1));
      check({n, " end tx"}, 32'(tx), 32'd1);
      check({n, " end ready"}, 32'(ready), 32'd1);
      check({n, " end busy"}, 32'(busy), 32'd0);
      prev = s;
    end

    // Identify from idle.
    ident_req = 1'b1;
    @(negedge clk);
    ident_req = 1'b0;
    check("idreq ready", 32'(ready), 32'd0);
    check("idreq busy", 32'(busy), 32'd1);
    ident_seq("idle", 0, last);

    // Identify requested mid-frame while the next keyboard byte waits.
    send("ovl", 8'h61, 1'b0);
    fork
      check_frame("ovl 61", 10'h2C2, s, rl, bl);
      begin
        ident_req = 1'b1;
        valid     = 1'b1;
        data      = 8'h62;
        @(negedge clk);
        ident_req = 1'b0;
      end
    join
    check("ovl 61 ready low", 32'(rl), 32'(FrameCyc));
    check("ovl 61 gap ready", 32'(ready), 32'd0);
    check("ovl 61 gap busy", 32'(busy), 32'd1);
    ident_seq("ovl", s, last);
    @(negedge clk);
    valid = 1'b0;
    check_frame("ovl 62", 10'h2C4, s, rl, bl);
    check("ovl 62 period", 32'(s - last), 32'(FrameCyc + 1));
    check("ovl 62 end ready", 32'(ready), 32'd1);
    check("ovl 62 end busy", 32'(busy), 32'd0);

    // Keyboard byte and identify request on the same idle cycle.
    send("sim", 8'h30, 1'b1);
    check_frame("sim 30", 10'h260, s, rl, bl);
    check("sim 30 gap ready", 32'(ready), 32'd0);
    check("sim 30 gap busy", 32'(busy), 32'd1);
    ident_seq("sim", s, last);

    // Reset during data bit 3 with an identify pending.
    send("rst", 8'hA5, 1'b1);
    repeat (16) @(negedge clk);
    check("rst bit3 tx", 32'(tx), 32'd0);
    check("rst bit3 busy", 32'(busy), 32'd1);
    clr_n = 1'b0;
    #1;
    check("rst async tx", 32'(tx), 32'd1);
    check("rst async busy", 32'(busy), 32'd0);
    check("rst async ready", 32'(ready), 32'd1);
    repeat (2) @(negedge clk);
    clr_n = 1'b1;
    dev = 1'b0;
    for (int i = 0; i < 120; i++) begin
      @(negedge clk);
      if (tx !== 1'b1 || ready !== 1'b1 || busy !== 1'b0) dev = 1'b1;
    end
    check("rst no ident after", 32'(dev), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/host_tx.md
# host_tx

Serial transmitter for the terminal-to-host direction. It accepts keyboard bytes over a valid/ready byte handshake and serialises them as 8N1 frames on the host line. It also generates the VT52 identify response (ESC `/` `K`) on request from the escape decoder. It sits opposite the host-side receiver path: the command side consumes host bytes, and this block produces them.

## Interface
- `BAUD_DIV`, default 2500: clock cycles per serial bit; legal values are 2 to 65535.
- `clk`  in  1: system clock, all logic on the rising edge.
- `clr_n`  in  1: reset, asynchronous, active-low.
- `data`  in  8: keyboard byte to transmit.
- `valid`  in  1: `data` is valid; the source holds `data` and `valid` until accepted.
- `ready`  out  1: block can accept a keyboard byte this cycle.
- `ident_req`  in  1: one-cycle pulse requesting the identify response.
- `tx`  out  1: serial line, idle high; registered output.
- `busy`  out  1: a frame is in progress or an identify byte is pending; registered output.

## Operation
- **States:**
  - `IDLE`: tx=1.
  - `START`: tx=0.
  - `DATA`: tx = shift[0], LSB first, 8 bits.
  - `STOP`: tx=1.
- **Each non-IDLE state** lasts BAUD_DIV cycles. The baud counter is 16 bits, loads BAUD_DIV-1 on entry and counts down to 0; there is no wrap or overflow for legal BAUD_DIV.
- **Bit index** is 3 bits. `DATA` exits to `STOP` after bit index 7 expires. `STOP` expiry returns to `IDLE`.
- **Identify state:**
  - `ident_pend` is set by `ident_req` in any state.
  - `seq_idx` is 2 bits and sequences bytes 0x1B, 0x2F, 0x4B.
  - The sequence is never interleaved with keyboard bytes.
- **`ready`** is combinational: it equals (state==`IDLE`) && !`ident_pend` && (`seq_idx`==0).
- **Keyboard accept:** when `valid` && `ready`, the byte is latched into the shift register and the state goes to `START`.
- **Identify start:** in `IDLE`, if `ident_pend` or `seq_idx`≠0, the next sequence byte is loaded into the shift register and the state goes to `START`.
  - Loading byte 0 clears `ident_pend` and sets `seq_idx`=1.
  - The byte at `seq_idx`=2 advances `seq_idx` to 0 after loading.
- **Priority:** identify has priority over keyboard only at byte boundaries. A frame already started always completes.
- **Simultaneous `valid` and `ident_req` in `IDLE`** with `ready`=1: the keyboard byte is accepted that cycle. `ident_pend` is set, and the sequence follows the keyboard frame.
- **`ident_req` while a sequence is active:** sets `ident_pend`, so one further full sequence follows. Multiple requests before byte 0 loads merge into one.
- **`busy`** = (state≠`IDLE`) || `ident_pend` || (`seq_idx`≠0), registered.

## Timing
- **Reset values** (while `clr_n`=0): state=`IDLE`, tx=1, busy=0, `ident_pend`=0, `seq_idx`=0, counters 0; `ready` reads 1.
- **Reset mid-frame:** tx returns to 1 asynchronously and the frame is dropped. Any pending or partial identify sequence is discarded.
- **Accept-to-line latency:** for a byte accepted at rising edge N, tx falls at edge N (registered, visible in cycle N+1).
- **Frame length:** exactly 10·BAUD_DIV cycles: start, 8 data bits, stop.
- **Return to ready:** the state returns to `IDLE` at the edge ending the stop bit, and `ready` is high for at least one cycle before the next acceptance.
- **Minimum period** between start-bit falling edges, keyboard or identify: 10·BAUD_DIV+1 cycles.
- **Identify sequence duration:** 3·(10·BAUD_DIV+1) cycles from the first load to the final `IDLE`.
- **Handshake:** `ready` never depends on `valid`. `data` is sampled only on the accepting edge.

## Test plan
- **Reset:** `clr_n`=0 then released, BAUD_DIV=4 -> tx=1, ready=1, busy=0 and stable with no stimulus.
- **Single byte:** send 0x41 with BAUD_DIV=4 -> tx bit sequence 0,1,0,0,0,0,0,1,0,1, each held 4 cycles. `ready` is low for exactly 40 cycles after acceptance.
- **Identify from idle:** `ident_req` pulse in `IDLE` -> frames 0x1B, 0x2F, 0x4B back-to-back, 41 cycles apart. `ready`=0 throughout; busy falls after the 0x4B stop bit.
- **Identify during keyboard frame:** `ident_req` during a 0x61 frame while `valid` is held with 0x62 -> the 0x61 frame completes, then 1B 2F 4B, then 0x62 is accepted.
- **Simultaneous request:** `valid`=1 (0x30) and `ident_req` on the same cycle in `IDLE` -> 0x30 is transmitted first, then the identify sequence.
- **Reset mid-frame:** `clr_n` asserted in bit 3 of a frame with `ident_pend` set -> tx=1 immediately. After release: `IDLE`, ready=1, and no identify bytes are sent.
